// File: rtl/alu_pkg.sv
// Shared types for the ALU checker slice: op encodings, FSM states, expected-result struct.
package alu_pkg;

    localparam int unsigned ALU_VEC_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_SHL = 4'd6,
        ALU_SHR = 4'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } chk_state_e;

    typedef struct packed {
        logic [ALU_VEC_W-1:0] sum;
        logic [ALU_VEC_W-1:0] mult;
        logic                 cout;
        logic                 flag;
    } alu_exp_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 32-bit ALU; reusable by any ALU bench or checker.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [ALU_VEC_W-1:0] a,
    input  logic [ALU_VEC_W-1:0] b,
    input  logic                 cin,
    input  logic [3:0]           sel,
    output alu_exp_t             exp_res
);

    logic [ALU_VEC_W:0]   add_full;
    logic [ALU_VEC_W:0]   sub_rhs;
    logic [ALU_VEC_W-1:0] s;
    logic                 co;

    // Decode the op, then derive mult and flag uniformly for every select
    always_comb begin
        add_full = {1'b0, a} + {1'b0, b} + (ALU_VEC_W + 1)'(cin);
        sub_rhs  = {1'b0, b} + (ALU_VEC_W + 1)'(cin);
        s        = '0;
        co       = 1'b0;
        case (sel)
            ALU_ADD: begin
                s  = add_full[ALU_VEC_W-1:0];
                co = add_full[ALU_VEC_W];
            end
            ALU_SUB: begin
                s  = a - b - ALU_VEC_W'(cin);
                // Borrow out: subtrahend plus borrow-in exceeds the minuend
                co = (sub_rhs > {1'b0, a});
            end
            ALU_AND: s = a & b;
            ALU_OR:  s = a | b;
            ALU_XOR: s = a ^ b;
            ALU_NOT: s = ~a;
            ALU_SHL: begin
                s  = {a[ALU_VEC_W-2:0], 1'b0};
                co = a[ALU_VEC_W-1];
            end
            ALU_SHR: begin
                s  = {1'b0, a[ALU_VEC_W-1:1]};
                co = a[0];
            end
            default: ;
        endcase
        exp_res.sum  = s;
        exp_res.mult = a * b;
        exp_res.cout = co;
        exp_res.flag = s[ALU_VEC_W-1];
    end

endmodule

// File: rtl/alu_checker.sv
// Streaming ALU response checker: golden compare over a 2-stage pipeline with run statistics.
// VEC_W must equal alu_pkg::ALU_VEC_W because the reference model is fixed at that width.
module alu_checker
    import alu_pkg::*;
#(
    parameter int unsigned VEC_W = ALU_VEC_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] in_a,
    input  logic [VEC_W-1:0] in_b,
    input  logic             in_cin,
    input  logic [3:0]       in_sel,
    input  logic [VEC_W-1:0] dut_sum,
    input  logic [VEC_W-1:0] dut_mult,
    input  logic             dut_cout,
    input  logic             dut_flag,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_seen,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [3:0]       first_fail_sel
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    chk_state_e       state;
    logic [CNT_W-1:0] num_vec_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             start_ok;
    logic             accept;
    alu_exp_t         exp_comb;

    // Stage 1: captured vector, DUT outputs and expected results
    logic             s1_valid;
    logic [CNT_W-1:0] s1_idx;
    logic [3:0]       s1_sel;
    alu_exp_t         s1_exp;
    logic [VEC_W-1:0] s1_sum;
    logic [VEC_W-1:0] s1_mult;
    logic             s1_cout;
    logic             s1_flag;
    logic             s1_fail;

    // Stage 2 only tracks occupancy; its compare result lands directly in the counters
    logic             s2_valid;

    assign in_ready = (state == StRun);
    assign accept   = in_valid & in_ready;
    assign start_ok = start & ((state == StIdle) | (state == StDone));

    alu_ref_model u_ref (
        .a       (in_a),
        .b       (in_b),
        .cin     (in_cin),
        .sel     (in_sel),
        .exp_res (exp_comb)
    );

    assign s1_fail = (s1_sum  != s1_exp.sum)  | (s1_mult != s1_exp.mult) |
                     (s1_cout != s1_exp.cout) | (s1_flag != s1_exp.flag);

    // Run-control FSM with registered busy/done
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            num_vec_q <= '0;
            acc_cnt   <= '0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        num_vec_q <= num_vec;
                        acc_cnt   <= '0;
                        if (num_vec == '0) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= StRun;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CntOne;
                        if (acc_cnt + CntOne == num_vec_q) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (!s1_valid && !s2_valid) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Pipeline valids; reset discards anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
        end
    end

    // Stage-1 data capture; contents are qualified by s1_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_idx  <= acc_cnt;
            s1_sel  <= in_sel;
            s1_exp  <= exp_comb;
            s1_sum  <= dut_sum;
            s1_mult <= dut_mult;
            s1_cout <= dut_cout;
            s1_flag <= dut_flag;
        end
    end

    // Stage-2 statistics: saturating counters and first-failure capture
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
            first_fail_sel <= '0;
        end else if (s1_valid) begin
            if (s1_fail) begin
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CntOne;
                end
                if (!fail_seen) begin
                    first_fail_idx <= s1_idx;
                    first_fail_sel <= s1_sel;
                end
                fail_seen <= 1'b1;
            end else if (pass_cnt != '1) begin
                pass_cnt <= pass_cnt + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// Self-checking bench for alu_checker: directed runs plus randomized vectors vs. an arithmetic model.
module tb_alu_checker;

    localparam int unsigned VEC_W = 32;
    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_a;
    logic [VEC_W-1:0] in_b;
    logic             in_cin;
    logic [3:0]       in_sel;
    logic [VEC_W-1:0] dut_sum;
    logic [VEC_W-1:0] dut_mult;
    logic             dut_cout;
    logic             dut_flag;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             fail_seen;
    logic [CNT_W-1:0] first_fail_idx;
    logic [3:0]       first_fail_sel;

    always #5 clk = ~clk;

    alu_checker #(
        .VEC_W (VEC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vec        (num_vec),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_cin         (in_cin),
        .in_sel         (in_sel),
        .dut_sum        (dut_sum),
        .dut_mult       (dut_mult),
        .dut_cout       (dut_cout),
        .dut_flag       (dut_flag),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .fail_seen      (fail_seen),
        .first_fail_idx (first_fail_idx),
        .first_fail_sel (first_fail_sel)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [3:0]  sel;
        logic [31:0] sum;
        logic [31:0] mult;
        logic        cout;
        logic        flag;
    } vec_t;

    vec_t vecs[16];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int          exp_pass;
    int          exp_fail;
    logic        exp_seen;
    int          exp_ffi;
    logic [3:0]  exp_ffs;
    int          lat;

    localparam longint unsigned Mod32 = 64'h1_0000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Arithmetic-level ALU model using 64-bit integers and modular reduction
    function automatic void golden(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                   input logic [3:0] sel, output logic [31:0] s,
                                   output logic [31:0] m, output logic co, output logic fl);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned uc = 64'(cin);
        longint unsigned r  = 0;
        co = 1'b0;
        case (sel)
            4'd0: begin r = ua + ub + uc; co = (r >= Mod32); end
            4'd1: begin r = (ua + 2 * Mod32 - ub - uc); co = ((ub + uc) > ua); end
            4'd2: r = 64'(a & b);
            4'd3: r = 64'(a | b);
            4'd4: r = 64'(a ^ b);
            4'd5: r = Mod32 - 1 - ua;
            4'd6: begin r = ua * 2; co = (ua >= Mod32 / 2); end
            4'd7: begin r = ua / 2; co = (ua % 2 == 1); end
            default: r = 0;
        endcase
        s  = 32'(r % Mod32);
        m  = 32'((ua * ub) % Mod32);
        fl = (64'(s) >= Mod32 / 2);
    endfunction

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [3:0] sel, input logic [31:0] s,
                           input logic [31:0] m, input logic co, input logic fl);
        vecs[i].a = a; vecs[i].b = b; vecs[i].cin = cin; vecs[i].sel = sel;
        vecs[i].sum = s; vecs[i].mult = m; vecs[i].cout = co; vecs[i].flag = fl;
    endtask

    // Random vector whose DUT fields are correct unless corrupt is set
    task automatic rand_vec(input int i, input bit corrupt);
        logic [31:0] s, m;
        logic        co, fl;
        vecs[i].a   = $urandom;
        vecs[i].b   = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
        vecs[i].cin = 1'($urandom_range(0, 1));
        vecs[i].sel = 4'($urandom_range(0, 15));
        golden(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel, s, m, co, fl);
        vecs[i].sum = s; vecs[i].mult = m; vecs[i].cout = co; vecs[i].flag = fl;
        if (corrupt) begin
            case ($urandom_range(0, 3))
                0:       vecs[i].sum  = s ^ (32'h1 << $urandom_range(0, 31));
                1:       vecs[i].mult = m ^ (32'h1 << $urandom_range(0, 31));
                2:       vecs[i].cout = ~co;
                default: vecs[i].flag = ~fl;
            endcase
        end
    endtask

    task automatic model_stats(input int n);
        logic [31:0] s, m;
        logic        co, fl;
        exp_pass = 0; exp_fail = 0; exp_seen = 1'b0; exp_ffi = 0; exp_ffs = '0;
        for (int i = 0; i < n; i++) begin
            golden(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sel, s, m, co, fl);
            if (s === vecs[i].sum && m === vecs[i].mult && co === vecs[i].cout &&
                fl === vecs[i].flag) begin
                exp_pass++;
            end else begin
                if (!exp_seen) begin
                    exp_ffi = i;
                    exp_ffs = vecs[i].sel;
                end
                exp_seen = 1'b1;
                exp_fail++;
            end
        end
    endtask

    task automatic drive_vec(input int i);
        in_valid = 1'b1;
        in_a = vecs[i].a; in_b = vecs[i].b; in_cin = vecs[i].cin; in_sel = vecs[i].sel;
        dut_sum = vecs[i].sum; dut_mult = vecs[i].mult;
        dut_cout = vecs[i].cout; dut_flag = vecs[i].flag;
    endtask

    task automatic pulse_start(input int n);
        start   = 1'b1;
        num_vec = CNT_W'(n);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // Run n back-to-back vectors; lat = edges from last accept until done is seen
    task automatic run_vecs(input string tag, input int n);
        pulse_start(n);
        check($sformatf("%s.busy_run", tag), 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            drive_vec(i);
            check($sformatf("%s.ready%0d", tag, i), 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_stats(input string tag, input int n);
        model_stats(n);
        check($sformatf("%s.done", tag), 32'(done), 32'd1);
        check($sformatf("%s.busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s.pass_cnt", tag), pass_cnt, 32'(exp_pass));
        check($sformatf("%s.fail_cnt", tag), fail_cnt, 32'(exp_fail));
        check($sformatf("%s.fail_seen", tag), 32'(fail_seen), 32'(exp_seen));
        check($sformatf("%s.ffi", tag), first_fail_idx, 32'(exp_ffi));
        check($sformatf("%s.ffs", tag), 32'(first_fail_sel), 32'(exp_ffs));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vec = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sel = '0;
        dut_sum = '0; dut_mult = '0; dut_cout = 1'b0; dut_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd0);
        check("rst.pass_cnt", pass_cnt, 32'd0);
        check("rst.fail_cnt", fail_cnt, 32'd0);
        check("rst.fail_seen", 32'(fail_seen), 32'd0);
        check("rst.ffi", first_fail_idx, 32'd0);
        check("rst.ffs", 32'(first_fail_sel), 32'd0);
        rst = 1'b0;

        // Single correct ADD, done exactly 3 edges after the accept
        set_vec(0, 32'd5, 32'd7, 1'b1, 4'd0, 32'd13, 32'd35, 1'b0, 1'b0);
        run_vecs("add1", 1);
        check("add1.latency", 32'(lat), 32'd3);
        check("add1.pass_const", pass_cnt, 32'd1);
        check_stats("add1", 1);

        // SUB 0-1: correct, then wrong flag
        set_vec(0, 32'd0, 32'd1, 1'b0, 4'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b1);
        run_vecs("sub_ok", 1);
        check("sub_ok.pass_const", pass_cnt, 32'd1);
        check_stats("sub_ok", 1);
        vecs[0].flag = 1'b0;
        run_vecs("sub_bad", 1);
        check("sub_bad.fail_const", fail_cnt, 32'd1);
        check("sub_bad.ffs_const", 32'(first_fail_sel), 32'd1);
        check_stats("sub_bad", 1);

        // Ten back-to-back with faults at 3 and 7
        for (int i = 0; i < 10; i++) rand_vec(i, (i == 3) || (i == 7));
        run_vecs("b2b", 10);
        check("b2b.latency", 32'(lat), 32'd3);
        check("b2b.pass_const", pass_cnt, 32'd8);
        check("b2b.fail_const", fail_cnt, 32'd2);
        check("b2b.ffi_const", first_fail_idx, 32'd3);
        check_stats("b2b", 10);

        // Zero-length run completes on the start edge and never opens in_ready
        pulse_start(0);
        check("zero.done", 32'(done), 32'd1);
        check("zero.busy", 32'(busy), 32'd0);
        check("zero.ready0", 32'(in_ready), 32'd0);
        check("zero.pass_cnt", pass_cnt, 32'd0);
        check("zero.fail_cnt", fail_cnt, 32'd0);
        check("zero.fail_seen", 32'(fail_seen), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("zero.ready%0d", k + 1), 32'(in_ready), 32'd0);
        end

        // Boundary vectors with hand-derived expectations
        set_vec(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        set_vec(1, 32'h8000_0000, 32'd0, 1'b0, 4'd6, 32'd0, 32'd0, 1'b1, 1'b0);
        set_vec(2, 32'd3, 32'd5, 1'b1, 4'd12, 32'd0, 32'd15, 1'b0, 1'b0);
        set_vec(3, 32'h0001_0000, 32'h0001_0000, 1'b0, 4'd2, 32'h0001_0000, 32'd0, 1'b0, 1'b0);
        set_vec(4, 32'h0000_0003, 32'd0, 1'b0, 4'd7, 32'd1, 32'd0, 1'b1, 1'b0);
        set_vec(5, 32'h0000_0000, 32'd9, 1'b0, 4'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        run_vecs("bound", 6);
        check("bound.pass_const", pass_cnt, 32'd6);
        check("bound.fail_const", fail_cnt, 32'd0);
        check_stats("bound", 6);

        // Random runs with random fault injection
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) rand_vec(i, $urandom_range(0, 3) == 0);
            run_vecs($sformatf("rnd%0d", r), 16);
            check($sformatf("rnd%0d.latency", r), 32'(lat), 32'd3);
            check_stats($sformatf("rnd%0d", r), 16);
        end

        // Reset after 4 of 8 accepts; vector 0 is faulty so a counter is live before reset
        for (int i = 0; i < 8; i++) rand_vec(i, i == 0);
        pulse_start(8);
        for (int i = 0; i < 4; i++) begin
            drive_vec(i);
            @(posedge clk); #1;
        end
        check("midrst.fail_before", fail_cnt, 32'd1);
        drive_vec(4);
        rst = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.done", 32'(done), 32'd0);
        check("midrst.ready", 32'(in_ready), 32'd0);
        check("midrst.pass_cnt", pass_cnt, 32'd0);
        check("midrst.fail_cnt", fail_cnt, 32'd0);
        check("midrst.fail_seen", 32'(fail_seen), 32'd0);
        check("midrst.ffi", first_fail_idx, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst.idle_pass", pass_cnt, 32'd0);
        check("midrst.idle_fail", fail_cnt, 32'd0);
        for (int i = 0; i < 8; i++) rand_vec(i, 1'b0);
        run_vecs("clean8", 8);
        check("clean8.pass_const", pass_cnt, 32'd8);
        check_stats("clean8", 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
